// File: rtl/axi4_mem_responder.sv
// AXI4 slave memory model: byte-enabled word array behind AW/W/B and AR/R.
// One write and one read burst in flight, independent channels.
module axi4_mem_responder #(
    parameter int                  ID_WIDTH     = 6,
    parameter int                  ADDR_WIDTH   = 64,
    parameter int                  DATA_WIDTH   = 512,
    parameter int                  DEPTH_LOG2   = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                  READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic [3:0]              s_axi_awregion,
    input  logic                    s_axi_awuser,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wuser,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_buser,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic [3:0]              s_axi_arregion,
    input  logic                    s_axi_aruser,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_ruser,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int SPAN     = DEPTH_LOG2 + ADDR_LSB;
    localparam int DEPTH    = 1 << DEPTH_LOG2;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
    localparam logic [1:0] INCR   = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    // Range decided on the start address only; DECERR outranks SLVERR.
    function automatic logic [1:0] req_resp(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        if (addr < BASE_ADDR || (off >> SPAN) != '0)
            return DECERR;
        if (burst != INCR)
            return SLVERR;
        return OKAY;
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_idx(
        input logic [ADDR_WIDTH-1:0] addr
    );
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return off[ADDR_LSB +: DEPTH_LOG2];
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    wstate_t               wstate;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [7:0]            w_len;
    logic [8:0]            w_beat;
    logic                  w_len_err;
    logic                  mem_we;

    rstate_t               rstate;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [7:0]            r_len;
    logic [7:0]            r_beat;
    logic [3:0]            r_cnt;

    logic unused_in;
    assign unused_in = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache,
                         s_axi_awprot, s_axi_awqos, s_axi_awregion,
                         s_axi_awuser, s_axi_wuser, s_axi_arsize,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot,
                         s_axi_arqos, s_axi_arregion, s_axi_aruser,
                         s_axi_arburst};

    assign s_axi_buser = 1'b0;
    assign s_axi_ruser = 1'b0;

    // Beats past awlen are absorbed; decode-error bursts never touch the array.
    assign mem_we = s_axi_wready && s_axi_wvalid &&
                    (w_beat <= {1'b0, w_len}) && (s_axi_bresp != DECERR);

    assign w_len_err = s_axi_wlast ? (w_beat != {1'b0, w_len})
                                   : (w_beat == {1'b0, w_len});

    // Byte-enabled array write; the array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (s_axi_wstrb[i])
                    mem[w_idx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
            end
        end
    end

    // Write FSM: address, then data beats, then a single response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate        <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= OKAY;
            w_idx         <= '0;
            w_len         <= '0;
            w_beat        <= '0;
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    if (s_axi_awready && s_axi_awvalid) begin
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        s_axi_bid     <= s_axi_awid;
                        s_axi_bresp   <= req_resp(s_axi_awaddr, s_axi_awburst);
                        w_idx         <= word_idx(s_axi_awaddr);
                        w_len         <= s_axi_awlen;
                        w_beat        <= '0;
                        wstate        <= W_DATA;
                    end else begin
                        s_axi_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid) begin
                        w_idx <= w_idx + 1'b1;
                        if (w_beat != '1)
                            w_beat <= w_beat + 1'b1;
                        if (w_len_err && s_axi_bresp == OKAY)
                            s_axi_bresp <= SLVERR;
                        if (s_axi_wlast) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            wstate       <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        wstate        <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read FSM: latency countdown, then back-to-back beats while rready holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate        <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rresp   <= OKAY;
            s_axi_rdata   <= '0;
            r_idx         <= '0;
            r_len         <= '0;
            r_beat        <= '0;
            r_cnt         <= '0;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (s_axi_arready && s_axi_arvalid) begin
                        s_axi_arready <= 1'b0;
                        s_axi_rid     <= s_axi_arid;
                        s_axi_rresp   <= req_resp(s_axi_araddr, s_axi_arburst);
                        r_idx         <= word_idx(s_axi_araddr);
                        r_len         <= s_axi_arlen;
                        r_beat        <= '0;
                        r_cnt         <= 4'(READ_LATENCY);
                        rstate        <= (READ_LATENCY == 0) ? R_DATA : R_WAIT;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == 4'd1)
                        rstate <= R_DATA;
                end
                R_DATA: begin
                    if (!s_axi_rvalid || (s_axi_rready && !s_axi_rlast)) begin
                        s_axi_rvalid <= 1'b1;
                        s_axi_rdata  <= (s_axi_rresp == DECERR) ? '0 : mem[r_idx];
                        s_axi_rlast  <= (r_beat == r_len);
                        r_idx        <= r_idx + 1'b1;
                        r_beat       <= r_beat + 1'b1;
                    end else if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_rlast   <= 1'b0;
                        s_axi_arready <= 1'b1;
                        rstate        <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi4_mem_responder.md
# axi4_mem_responder

AXI4 slave memory model answering the master port of the NoC-to-AXI4 bridge. It accepts AW/W/AR requests, stores write data in an internal byte-enabled array, and returns R/B responses with a configurable read latency. It sits at the memory end of the chipset path and serves as a stand-in for the DDR controller in simulation and FPGA bring-up. One write and one read transaction are in flight at a time, with independent channels.

## Interface
- ID_WIDTH, 6: AXI ID width.
- ADDR_WIDTH, 64: AXI address width.
- DATA_WIDTH, 512: AXI data width; power of 2, ≥ 64.
- DEPTH_LOG2, 10: log2 of the number of DATA_WIDTH words in the array.
- BASE_ADDR, 0: byte address mapped to word 0.
- READ_LATENCY, 2: idle cycles from AR handshake to the first rvalid; range 0..15.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_axi_awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1  write address.
- s_axi_awready  out  1.
- s_axi_wdata/wstrb/wlast/wvalid  in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data.
- s_axi_wready  out  1.
- s_axi_bid/bresp/bvalid  out  ID_WIDTH/2/1  write response; s_axi_bready in 1.
- s_axi_arid/araddr/arlen/arsize/arburst/arvalid  in  as AW  read address; s_axi_arready out 1.
- s_axi_rid/rdata/rresp/rlast/rvalid  out  ID_WIDTH/DATA_WIDTH/2/1/1  read data; s_axi_rready in 1.
- Lock, cache, prot, qos, region and user inputs are present and ignored. user outputs are tied to 0.

## Operation
- ADDR_LSB = log2(DATA_WIDTH/8). Word index = (addr − BASE_ADDR) >> ADDR_LSB, taken mod 2^DEPTH_LOG2 on increment.
- A request is in range if BASE_ADDR ≤ addr < BASE_ADDR + 2^(DEPTH_LOG2+ADDR_LSB). The check uses the start address only.
- awsize/arsize are ignored. Every beat is a full word. Each beat increments the index by 1, and the index wraps at the top of the array.
- Burst type is checked: INCR gives OKAY. FIXED or WRAP gives SLVERR, and the burst is still executed as INCR.
- An out-of-range request gives DECERR. DECERR takes priority over SLVERR. Writes are dropped and read beats return rdata = 0.
- The array is not reset. Contents after reset are undefined until written.
- Write FSM:
  - W_IDLE: awready = 1. On the AW handshake, latch id, index, len and resp, then go to W_DATA.
  - W_DATA: wready = 1. Each W handshake writes the bytes whose wstrb bits are set, then the index increments. When the handshake has wlast = 1, go to W_RESP.
  - Length check: if wlast arrives on a beat ≠ awlen, or is absent on beat awlen, bresp = SLVERR. Beats past awlen are absorbed and not written.
  - W_RESP: bvalid = 1, with bid = latched id and bresp = latched resp. On bready, return to W_IDLE.
- Read FSM:
  - R_IDLE: arready = 1. On the AR handshake, latch the fields, load the latency counter and go to R_WAIT. If READ_LATENCY = 0, go directly to R_DATA.
  - R_WAIT: count down, then go to R_DATA.
  - R_DATA: rvalid = 1, with rid = latched id, rresp = latched resp, and rlast = 1 when the beat count equals arlen.
  - rdata is registered from the array at the cycle the beat is loaded. It holds stable while rvalid && !rready.
  - On each R handshake, load the next beat on the next edge. There are no bubbles while rready stays high.
  - After the handshake on the last beat, return to R_IDLE.
- Read/write collision: an array write in the same cycle as the read-register load of the same word is not visible to that beat. The beat returns the old data.

## Timing
- During reset all outputs are 0, including awready and arready. FSMs go to W_IDLE/R_IDLE. In the first cycle after rst_n rises, awready = arready = 1.
- AW to first wready: 1 cycle. Last W to bvalid: 1 cycle. bready to awready: 1 cycle.
- AR handshake at edge N gives first rvalid after edge N+1+READ_LATENCY. With rready held at 1, a burst of len+1 beats occupies consecutive cycles.
- After the last R handshake, arready is high on the next cycle.
- Outputs hold valid/data stable until the handshake; the block never drops valid before the handshake.
- awready and wready are never high at the same time. Write address and data are strictly sequential.
- rst_n asserted mid-burst: outputs clear immediately and asynchronously, and the burst is abandoned. Array writes already committed remain.

## Test plan
- Reset: hold rst_n = 0 for 5 cycles → all outputs 0. One cycle after release → awready = arready = 1.
- Single write then read: AW addr=BASE_ADDR+0x40, len=0, id=3, W data=0x…A5, wstrb all ones → bresp = OKAY, bid = 3. AR to the same address with READ_LATENCY = 2 → rvalid 3 cycles after the AR edge, rdata = 0x…A5, rlast = 1, rid = 3.
- Burst with backpressure: 4-beat INCR write of words 1..4, then a 4-beat read with rready toggling 1,0,1,0… → beats return 1..4 in order, rdata stable across stalls, rlast only on beat 4.
- Byte strobes: write 0xFF…FF, then write 0 with wstrb = 0x1 → read returns 0xFF…FF00.
- Errors: AR addr = BASE_ADDR + array size → DECERR, rdata = 0. AW with burst = FIXED → bresp SLVERR. AW len = 1 with wlast on beat 0 → SLVERR.
- Concurrency and wrap: read and write to the same word in the same cycle → the read returns old data. A burst starting at the last word with len = 1 → the second beat accesses word 0.
